flip_sequencer: RTL and testbench

Controller that owns a ROWS x COLS binary matrix register and drives the rectangle-flip datapath with a queued stream of rectangle commands, applying one flip per cycle. Host loads an initial matrix, streams (r1,r2,c1,c2) commands over valid/ready into an internal FIFO, marks the last one, and reads the final matrix when done. Sits between the rectangle-loop search logic and the combinational flip unit.

---
 rtl/flip_sequencer.sv | 178 +++++++++++++++++
 tb/tb_flip_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/flip_sequencer.sv
// flip_sequencer: holds a ROWS x COLS binary matrix and applies a stream of
// rectangle-flip commands to it, one flip per cycle, from a small FIFO.
// Optional build macro FLIP_SEQ_ABORT_EN adds an abort input and an aborted
// status output. This lets the host cancel a running job.
module flip_sequencer #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int DEPTH = 4,
  parameter int RW    = $clog2(ROWS),
  parameter int CW    = $clog2(COLS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_valid,
  input  logic [ROWS*COLS-1:0] load_data,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [RW-1:0]        cmd_r1,
  input  logic [RW-1:0]        cmd_r2,
  input  logic [CW-1:0]        cmd_c1,
  input  logic [CW-1:0]        cmd_c2,
  input  logic                 cmd_last,
  output logic [ROWS*COLS-1:0] m_out,
  output logic                 busy,
  output logic                 done,
`ifdef FLIP_SEQ_ABORT_EN
  input  logic                 abort,
  output logic                 aborted,
`endif
  output logic [15:0]          flip_count
);

  localparam int N  = ROWS * COLS;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Queue entries hold already clamped and ordered bounds.
  typedef struct packed {
    logic          last;
    logic [RW-1:0] rlo;
    logic [RW-1:0] rhi;
    logic [CW-1:0] clo;
    logic [CW-1:0] chi;
  } cmd_t;

  state_t        state_q;
  logic [N-1:0]  m_q;
  logic [15:0]   cnt_q;
  logic          last_seen_q;
  logic [AW:0]   wr_q;
  logic [AW:0]   rd_q;
  cmd_t          fifo_q [DEPTH];
`ifdef FLIP_SEQ_ABORT_EN
  logic          aborted_q;
`endif

  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  cmd_t          head;
  cmd_t          cmd_d;
  logic [N-1:0]  m_d;
  logic [15:0]   cnt_d;

  function automatic logic [RW-1:0] clamp_r(input logic [RW-1:0] v);
    if (int'(v) > ROWS - 1) return RW'(ROWS - 1);
    return v;
  endfunction

  function automatic logic [CW-1:0] clamp_c(input logic [CW-1:0] v);
    if (int'(v) > COLS - 1) return CW'(COLS - 1);
    return v;
  endfunction

  function automatic logic [N-1:0] rect_mask(input cmd_t e);
    logic [N-1:0] mk;
    mk = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        mk[r*COLS+c] = (r >= int'(e.rlo)) && (r <= int'(e.rhi)) &&
                       (c >= int'(e.clo)) && (c <= int'(e.chi));
      end
    end
    return mk;
  endfunction

  assign fifo_empty = (wr_q == rd_q);
  assign fifo_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign cmd_ready  = (state_q == RUN) && !fifo_full && !last_seen_q;
  assign push       = cmd_valid && cmd_ready;
  assign head       = fifo_q[rd_q[AW-1:0]];

  // Normalise the incoming command and form the next matrix and count.
  always_comb begin
    logic [RW-1:0] r1, r2;
    logic [CW-1:0] c1, c2;
    r1 = clamp_r(cmd_r1);
    r2 = clamp_r(cmd_r2);
    c1 = clamp_c(cmd_c1);
    c2 = clamp_c(cmd_c2);
    cmd_d.last = cmd_last;
    cmd_d.rlo  = (r1 < r2) ? r1 : r2;
    cmd_d.rhi  = (r1 < r2) ? r2 : r1;
    cmd_d.clo  = (c1 < c2) ? c1 : c2;
    cmd_d.chi  = (c1 < c2) ? c2 : c1;
    m_d        = m_q ^ rect_mask(head);
    cnt_d      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  end

  // Command storage; contents need no reset because pointers gate them.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_q[AW-1:0]] <= cmd_d;
  end

  // Sequencer FSM: load, queue commands, apply one flip per cycle, finish.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      m_q         <= '0;
      cnt_q       <= '0;
      last_seen_q <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
`ifdef FLIP_SEQ_ABORT_EN
      aborted_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (load_valid) begin
            m_q         <= load_data;
            cnt_q       <= '0;
            last_seen_q <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
`ifdef FLIP_SEQ_ABORT_EN
            aborted_q   <= 1'b0;
`endif
            state_q     <= RUN;
          end
        end
        RUN: begin
`ifdef FLIP_SEQ_ABORT_EN
          if (abort) begin
            wr_q      <= '0;
            rd_q      <= '0;
            aborted_q <= 1'b1;
            state_q   <= DONE;
          end else
`endif
          begin
            if (push) begin
              wr_q <= wr_q + 1'b1;
              if (cmd_last) last_seen_q <= 1'b1;
            end
            if (!fifo_empty) begin
              rd_q  <= rd_q + 1'b1;
              m_q   <= m_d;
              cnt_q <= cnt_d;
              if (head.last) state_q <= DONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_out      = m_q;
  assign flip_count = cnt_q;
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
`ifdef FLIP_SEQ_ABORT_EN
  assign aborted    = aborted_q;
`endif

endmodule

// File: tb/tb_flip_sequencer.sv
// Scoreboard bench for flip_sequencer (4x4 matrix, depth 4).
module tb_flip_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [15:0] load_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_r1, cmd_r2, cmd_c1, cmd_c2;
  logic        cmd_last;
  logic [15:0] m_out;
  logic        busy, done;
  logic [15:0] flip_count;
`ifdef FLIP_SEQ_ABORT_EN
  logic        abort;
  logic        aborted;
`endif

  flip_sequencer #(.ROWS(4), .COLS(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_r1(cmd_r1), .cmd_r2(cmd_r2), .cmd_c1(cmd_c1), .cmd_c2(cmd_c2),
    .cmd_last(cmd_last), .m_out(m_out), .busy(busy), .done(done),
`ifdef FLIP_SEQ_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .flip_count(flip_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] m;
    logic [15:0] c;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Acceptance tracker: a command accepted at edge N must be applied at N+1.
  logic pend1 = 1'b0, pend2 = 1'b0;
  logic stop_now;
  always @(posedge clk) begin
    pend1 <= reset && cmd_valid && cmd_ready;
`ifdef FLIP_SEQ_ABORT_EN
    stop_now = !reset || abort;
`else
    stop_now = !reset;
`endif
    pend2 <= pend1 && !stop_now;
  end

  // Monitor: compare the flipped matrix with the scoreboard head.
  always @(negedge clk) begin
    if (pend2) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_m_out", {16'd0, m_out}, {16'd0, e.m});
        chk("sb_flip_count", {16'd0, flip_count}, {16'd0, e.c});
      end
    end
  end

  task automatic load(input logic [15:0] d);
    load_data  = d;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // Drive a command from a negedge, hold until accepted, return at a negedge.
  task automatic send_cmd(input int r1, input int r2, input int c1, input int c2,
                          input bit last, input logic [15:0] em, input logic [15:0] ec);
    bit ok;
    exp_t e;
    ok        = 1'b0;
    cmd_r1    = 2'(r1);
    cmd_r2    = 2'(r2);
    cmd_c1    = 2'(c1);
    cmd_c2    = 2'(c2);
    cmd_last  = last;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (cmd_ready) begin
        e.m = em;
        e.c = ec;
        exp_q.push_back(e);
        ok = 1'b1;
      end
      @(negedge clk);
    end
    if (!ok) chk("cmd_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    cmd_last  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; load_valid = 1'b0; load_data = '0;
    cmd_valid = 1'b0; cmd_last = 1'b0;
    cmd_r1 = '0; cmd_r2 = '0; cmd_c1 = '0; cmd_c2 = '0;
`ifdef FLIP_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_m_out", {16'd0, m_out}, 32'h0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_flip_count", {16'd0, flip_count}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd0);

    // Single 2x2 flip
    load(16'h0000);
    chk("load_busy", {31'd0, busy}, 32'd1);
    send_cmd(0, 1, 0, 1, 1'b1, 16'h0033, 16'd1);
    idle(1);
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_busy", {31'd0, busy}, 32'd0);
    chk("t2_m_out", {16'd0, m_out}, 32'h0033);
    chk("t2_flip_count", {16'd0, flip_count}, 32'd1);
    chk("done_cmd_ready", {31'd0, cmd_ready}, 32'd0);

    // Reversed bounds, load taken from DONE
    load(16'h0000);
    chk("reload_flip_count", {16'd0, flip_count}, 32'd0);
    send_cmd(3, 2, 3, 3, 1'b1, 16'h8800, 16'd1);
    idle(1);
    chk("t3_m_out", {16'd0, m_out}, 32'h8800);

    // Back-to-back commands: one flip per cycle
    load(16'hFFFF);
    send_cmd(0, 3, 0, 3, 1'b0, 16'h0000, 16'd1);
    send_cmd(1, 1, 2, 2, 1'b1, 16'h0040, 16'd2);
    idle(1);
    chk("t4_m_out", {16'd0, m_out}, 32'h0040);
    chk("t4_flip_count", {16'd0, flip_count}, 32'd2);
    chk("t4_done", {31'd0, done}, 32'd1);

    // Six commands with gaps, each rectangle twice; load ignored in RUN
    load(16'h1234);
    send_cmd(0, 0, 0, 3, 1'b0, 16'h123B, 16'd1);
    idle(2);
    chk("t5_ready_gap", {31'd0, cmd_ready}, 32'd1);
    send_cmd(3, 1, 2, 0, 1'b0, 16'h654B, 16'd2);
    send_cmd(0, 0, 3, 0, 1'b0, 16'h6544, 16'd3);
    idle(1);
    load_data = 16'hAAAA; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    chk("t5_load_ignored_m", {16'd0, m_out}, 32'h6544);
    chk("t5_load_ignored_cnt", {16'd0, flip_count}, 32'd3);
    send_cmd(2, 2, 1, 1, 1'b0, 16'h6744, 16'd4);
    idle(3);
    send_cmd(1, 3, 0, 2, 1'b0, 16'h1034, 16'd5);
    send_cmd(2, 2, 1, 1, 1'b1, 16'h1234, 16'd6);
    chk("t5_ready_after_last", {31'd0, cmd_ready}, 32'd0);
    idle(1);
    chk("t5_m_out", {16'd0, m_out}, 32'h1234);
    chk("t5_flip_count", {16'd0, flip_count}, 32'd6);
    chk("t5_done", {31'd0, done}, 32'd1);

    // Reset in the middle of a job
    load(16'h0F0F);
    send_cmd(0, 0, 0, 0, 1'b0, 16'h0F0E, 16'd1);
    send_cmd(1, 1, 1, 1, 1'b0, 16'h0F2E, 16'd2);
    send_cmd(2, 2, 2, 2, 1'b0, 16'h0B2E, 16'd3);
    cmd_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    exp_q.delete();
    chk("t6_m_out", {16'd0, m_out}, 32'h0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_done", {31'd0, done}, 32'd0);
    chk("t6_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("t6_flip_count", {16'd0, flip_count}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

`ifdef FLIP_SEQ_ABORT_EN
    // Abort while running
    load(16'h00FF);
    send_cmd(0, 0, 0, 0, 1'b0, 16'h00FE, 16'd1);
    cmd_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    exp_q.delete();
    chk("ab_done", {31'd0, done}, 32'd1);
    chk("ab_aborted", {31'd0, aborted}, 32'd1);
    chk("ab_m_out", {16'd0, m_out}, 32'h00FF);
    chk("ab_flip_count", {16'd0, flip_count}, 32'd0);
    load(16'h0001);
    chk("ab_cleared", {31'd0, aborted}, 32'd0);
`endif

    idle(2);
    chk("sb_leftover", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
